cc_egr_protocol_error_collector: RTL

- Sits directly downstream of the egress protocol monitor. Consumes its per-cycle 16-bit protocol_error vector and its protocol_error_ap_vld qualifier.
- Turns per-cycle fault flags into software-visible state: a sticky W1C status, first-error snapshot with timestamp, saturating event count, and a level interrupt.
- Feeds the chain-control register block and the interrupt aggregator.

---
 rtl/cc_egr_protocol_error_collector_pkg.sv | 39 +++
 rtl/cc_egr_protocol_error_collector_if.sv | 42 ++++
 rtl/cc_egr_protocol_error_collector_sat_counter.sv | 42 ++++
 rtl/cc_egr_protocol_error_collector.sv | 115 +++++++++++
 4 files changed

// File: rtl/cc_egr_protocol_error_collector_pkg.sv
// Package for the egress protocol error collector.
// Holds the monitor's fault-bit positions, the reserved-bit mask, the
// vector width, the first-error capture state encoding and the helper
// that filters a raw fault vector down to its effective bits.
package cc_egr_monitor_pkg;

  localparam int PROTOCOL_ERROR_W = 16;

  // Bit positions of the monitor's fault vector
  localparam int RESP_CHANNEL_EQ_REQ      = 0;
  localparam int RESP_BURST_LENGTH_LE_REQ = 1;
  localparam int RESP_SOF_EQ_REQ          = 2;
  localparam int RESP_EOF_EQ_REQ          = 3;
  localparam int RESP_TRANS_CW_REQ        = 4;
  localparam int DATA_TRANS_CW_RESP       = 5;
  localparam int REQ_OUTSTANDING          = 6;
  localparam int RESP_OUTSTANDING         = 7;
  localparam int DATA_OUTSTANDING         = 8;
  localparam int REQ_MAX_BURST_LENGTH     = 9;
  localparam int REQ_BURST_LENGTH_NZ      = 12;
  localparam int RESP_BURST_LENGTH_EQ_REQ = 13;

  // Bits 15,14,11,10 are not driven by the monitor and never count
  localparam logic [PROTOCOL_ERROR_W-1:0] RESERVED_MASK = 16'hCC00;

  typedef enum logic [0:0] {
    ARMED    = 1'b0,
    CAPTURED = 1'b1
  } first_state_e;

  // Raw vector with software-masked and reserved bits removed
  function automatic logic [PROTOCOL_ERROR_W-1:0] effective_vec(
    input logic [PROTOCOL_ERROR_W-1:0] raw,
    input logic [PROTOCOL_ERROR_W-1:0] mask
  );
    return raw & ~mask & ~RESERVED_MASK;
  endfunction

endpackage

// File: rtl/cc_egr_protocol_error_collector_if.sv
// Interface bundling the collector's monitor input, software controls and
// software-visible state.
//   slave  : used by the collector (monitor/controls in, state out)
//   master : used by whoever drives the monitor side and the controls
// Parameters CNT_W / TS_W size error_count and first_error_time.
interface cc_egr_protocol_error_collector_if #(
  parameter int CNT_W = 32,
  parameter int TS_W  = 48
);
  import cc_egr_monitor_pkg::*;

  logic [PROTOCOL_ERROR_W-1:0] protocol_error;
  logic                        protocol_error_ap_vld;
  logic [PROTOCOL_ERROR_W-1:0] error_mask;
  logic                        irq_enable;
  logic                        status_clear_valid;
  logic [PROTOCOL_ERROR_W-1:0] status_clear_bits;
  logic                        count_clear;
  logic                        first_rearm;

  logic [PROTOCOL_ERROR_W-1:0] error_status;
  logic [PROTOCOL_ERROR_W-1:0] first_error;
  logic [TS_W-1:0]             first_error_time;
  logic                        first_error_valid;
  logic [CNT_W-1:0]            error_count;
  logic                        error_irq;

  modport slave (
    input  protocol_error, protocol_error_ap_vld, error_mask, irq_enable,
           status_clear_valid, status_clear_bits, count_clear, first_rearm,
    output error_status, first_error, first_error_time, first_error_valid,
           error_count, error_irq
  );

  modport master (
    output protocol_error, protocol_error_ap_vld, error_mask, irq_enable,
           status_clear_valid, status_clear_bits, count_clear, first_rearm,
    input  error_status, first_error, first_error_time, first_error_valid,
           error_count, error_irq
  );

endinterface

// File: rtl/cc_egr_protocol_error_collector_sat_counter.sv
// cc_sat_counter: W-bit saturating up-counter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : add one (held at all-ones once reached)
//   clr      : zero the count; clr together with inc yields 1
//   count    : registered count value
module cc_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear dominates history, the event in the same cycle still counts
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : W'(0);
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= W'(0);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cc_egr_protocol_error_collector.sv
// cc_egr_protocol_error_collector: turns the egress protocol monitor's
// per-cycle fault vector into sticky W1C status, a first-error snapshot with
// timestamp, a saturating event count and a level interrupt.
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   bus (slave)    : monitor vector + qualifier, mask, irq enable, W1C clear,
//                    count clear, re-arm in; status/snapshot/count/irq out
// Every output reflects an event sampled in cycle N at cycle N+1.
module cc_egr_protocol_error_collector
  import cc_egr_monitor_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TS_W  = 48
) (
  input  logic ap_clk,
  input  logic ap_rst,
  cc_egr_protocol_error_collector_if.slave bus
);

  logic [PROTOCOL_ERROR_W-1:0] eff_s;
  logic                        event_s;
  logic [PROTOCOL_ERROR_W-1:0] clr_mask_s;

  logic [PROTOCOL_ERROR_W-1:0] status_q, status_d;
  logic                        irq_q, irq_d;
  logic [TS_W-1:0]             ts_q, ts_d;

  first_state_e                state_q;
  logic [PROTOCOL_ERROR_W-1:0] first_error_q;
  logic [TS_W-1:0]             first_time_q;
  logic                        first_valid_q;

  // Event detection and next-state of status, interrupt and timestamp
  always_comb begin
    eff_s   = effective_vec(bus.protocol_error, bus.error_mask);
    event_s = bus.protocol_error_ap_vld && (eff_s != 16'h0000);
    if (bus.status_clear_valid) begin
      clr_mask_s = bus.status_clear_bits;
    end else begin
      clr_mask_s = 16'h0000;
    end
    // Set is OR'd in after the clear so a same-cycle set wins
    status_d = (status_q & ~clr_mask_s) | (event_s ? eff_s : 16'h0000);
    // Interrupt follows the next status so it lines up with it at N+1
    irq_d    = bus.irq_enable & (|status_d);
    ts_d     = ts_q + TS_W'(1);
  end

  // Status, interrupt and free-running timestamp registers
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      status_q <= 16'h0000;
      irq_q    <= 1'b0;
      ts_q     <= TS_W'(0);
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
      ts_q     <= ts_d;
    end
  end

  // First-error capture FSM with registered snapshot outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= ARMED;
      first_error_q <= 16'h0000;
      first_time_q  <= TS_W'(0);
      first_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (event_s) begin
            first_error_q <= eff_s;
            first_time_q  <= ts_q;
            first_valid_q <= 1'b1;
            state_q       <= CAPTURED;
          end
        end
        CAPTURED: begin
          if (event_s && bus.first_rearm) begin
            // Re-arm and capture collapse into an immediate new snapshot
            first_error_q <= eff_s;
            first_time_q  <= ts_q;
            first_valid_q <= 1'b1;
          end else if (bus.first_rearm) begin
            first_error_q <= 16'h0000;
            first_time_q  <= TS_W'(0);
            first_valid_q <= 1'b0;
            state_q       <= ARMED;
          end
        end
        default: begin
          first_error_q <= 16'h0000;
          first_time_q  <= TS_W'(0);
          first_valid_q <= 1'b0;
          state_q       <= ARMED;
        end
      endcase
    end
  end

  cc_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .inc   (event_s),
    .clr   (bus.count_clear),
    .count (bus.error_count)
  );

  assign bus.error_status      = status_q;
  assign bus.error_irq         = irq_q;
  assign bus.first_error       = first_error_q;
  assign bus.first_error_time  = first_time_q;
  assign bus.first_error_valid = first_valid_q;

endmodule
